// File: rtl/sim_event_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : sim_event_pkg                                           |
// | Description : Shared modes, channel states and event record for the   |
// |               simulation event counter family.                        |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package sim_event_pkg;

  // Channel modes; an event's kind is the mode of the channel that raised it
  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STOP   = 2'd1;
  localparam logic [1:0] MODE_FINISH = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'd3;

  // Event record fields are sized for the largest supported configuration
  // (16 channels, 32-bit timestamps); narrower instances zero-extend.
  localparam int EVT_CH_MAX_W = 4;
  localparam int EVT_TS_MAX_W = 32;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [EVT_CH_MAX_W-1:0] ch;
    logic [1:0]              kind;
    logic [EVT_TS_MAX_W-1:0] ts;
  } evt_entry_t;

endpackage
`default_nettype wire

// File: rtl/sim_event_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : sim_event_fifo                                          |
// | Description : First-word-fall-through FIFO; head data is visible      |
// |               whenever o_empty is low. Push on a full FIFO is taken   |
// |               only when a pop happens in the same cycle.              |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module sim_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit to tell full from empty
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  // Read/write pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/sim_event_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : sim_event_counter                                       |
// | Description : Multi-channel terminal counter raising timestamped      |
// |               stop/finish/reload events into an event FIFO; popped    |
// |               events drive stop_req (pulse) and finish_req (sticky).  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module sim_event_counter
  import sim_event_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    i_cfg_we,
  input  logic [CH_W-1:0]         i_cfg_ch,
  input  logic [CNT_W-1:0]        i_cfg_limit,
  input  logic [1:0]              i_cfg_mode,
  output logic [NUM_CH*CNT_W-1:0] o_count,
  output logic [NUM_CH-1:0]       o_done,
  output logic                    o_evt_valid,
  input  logic                    i_evt_ready,
  output logic [CH_W-1:0]         o_evt_ch,
  output logic [1:0]              o_evt_kind,
  output logic [TS_W-1:0]         o_evt_time,
  output logic                    o_overflow,
  output logic                    o_stop_req,
  output logic                    o_finish_req
);

  logic [TS_W-1:0]   r_ts;
  logic              r_overflow;
  logic              r_stop_req;
  logic              r_finish_req;

  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_gnt;
  logic [NUM_CH-1:0] w_ovf_set;
  logic [1:0]        w_kind [NUM_CH];
  logic [TS_W-1:0]   w_pts  [NUM_CH];

  logic              w_found;
  logic [CH_W-1:0]   w_gnt_idx;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_can_push;
  evt_entry_t        w_push_data;
  evt_entry_t        w_head;
  logic              w_unused_head;

  // Free-running timestamp, independent of the count enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic [TS_W-1:0]  r_pts;
    logic             w_cfg_sel;
    logic             w_run;
    logic             w_hit;

    // A configuration write to this channel overrides a coincident hit
    assign w_cfg_sel = i_cfg_we && (i_cfg_ch == CH_W'(g));
    assign w_hit     = w_run && i_enable && (r_cnt == r_limit) && !w_cfg_sel;
    // A hit is only lost if the earlier pending event is not leaving this cycle
    assign w_ovf_set[g] = w_hit && r_pend && !w_gnt[g];

    // Channel state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= CH_IDLE;
      else        r_state <= w_state_nxt;
    end

    // Channel next state: configure, or complete a one-shot on its hit
    always_comb begin
      w_state_nxt = r_state;
      if (w_cfg_sel)
        w_state_nxt = (i_cfg_mode != MODE_OFF) ? CH_RUN : CH_IDLE;
      else if (w_hit && (r_mode != MODE_RELOAD))
        w_state_nxt = CH_DONE;
    end

    // Channel state decode
    always_comb begin
      w_run     = (r_state == CH_RUN);
      o_done[g] = (r_state == CH_DONE);
    end

    // Configuration, counting and pending-event capture
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mode  <= MODE_OFF;
        r_limit <= '0;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_pts   <= '0;
      end else if (w_cfg_sel) begin
        r_mode  <= i_cfg_mode;
        r_limit <= i_cfg_limit;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
      end else begin
        if (w_run && i_enable) begin
          if (r_cnt != r_limit)          r_cnt <= r_cnt + 1'b1;
          else if (r_mode == MODE_RELOAD) r_cnt <= '0;
        end
        if (w_hit) begin
          if (!r_pend || w_gnt[g]) begin
            r_pend <= 1'b1;
            r_pts  <= r_ts;
          end
        end else if (w_gnt[g]) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign w_pend[g]                  = r_pend;
    assign w_kind[g]                  = r_mode;
    assign w_pts[g]                   = r_pts;
    assign o_count[g*CNT_W +: CNT_W]  = r_cnt;
  end

  assign w_pop      = !w_empty && i_evt_ready;
  assign w_can_push = !w_full || w_pop;

  // Fixed-priority arbiter: lowest-index pending channel wins the single push slot
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_pend[i] && !w_found) begin
        w_found   = 1'b1;
        w_gnt_idx = CH_W'(i);
      end
    end
    w_push = w_found && w_can_push;
    w_gnt  = w_push ? (NUM_CH'(1) << w_gnt_idx) : '0;
  end

  // Event record for the granted channel
  always_comb begin
    w_push_data      = '0;
    w_push_data.ch   = EVT_CH_MAX_W'(w_gnt_idx);
    w_push_data.kind = w_kind[w_gnt_idx];
    w_push_data.ts   = EVT_TS_MAX_W'(w_pts[w_gnt_idx]);
  end

  sim_event_fifo #(
    .WIDTH ($bits(evt_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Upper record bits are unused in narrower configurations
  assign w_unused_head = ^w_head;

  // Sticky overflow and request outputs driven by popped events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_stop_req   <= 1'b0;
      r_finish_req <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (|w_ovf_set);
      r_stop_req <= w_pop && (w_head.kind == MODE_STOP);
      if (w_pop && (w_head.kind == MODE_FINISH)) r_finish_req <= 1'b1;
    end
  end

  // Head fields read as zero while the FIFO is empty
  assign o_evt_valid  = !w_empty;
  assign o_evt_ch     = w_empty ? '0 : w_head.ch[CH_W-1:0];
  assign o_evt_kind   = w_empty ? '0 : w_head.kind;
  assign o_evt_time   = w_empty ? '0 : w_head.ts[TS_W-1:0];
  assign o_overflow   = r_overflow;
  assign o_stop_req   = r_stop_req;
  assign o_finish_req = r_finish_req;

endmodule
`default_nettype wire

// File: tb/tb_sim_event_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_sim_event_counter                                    |
// | Description : Directed scenarios followed by random traffic, checked  |
// |               every cycle against a queue-based reference model.      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_sim_event_counter;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TS_W       = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic                    cfg_we;
  logic [1:0]              cfg_ch;
  logic [CNT_W-1:0]        cfg_limit;
  logic [1:0]              cfg_mode;
  logic                    evt_ready;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       done;
  logic                    evt_valid;
  logic [1:0]              evt_ch;
  logic [1:0]              evt_kind;
  logic [TS_W-1:0]         evt_time;
  logic                    overflow;
  logic                    stop_req;
  logic                    finish_req;

  always #5 clk = ~clk;

  sim_event_counter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_cfg_we(cfg_we),
    .i_cfg_ch(cfg_ch), .i_cfg_limit(cfg_limit), .i_cfg_mode(cfg_mode),
    .o_count(count), .o_done(done), .o_evt_valid(evt_valid),
    .i_evt_ready(evt_ready), .o_evt_ch(evt_ch), .o_evt_kind(evt_kind),
    .o_evt_time(evt_time), .o_overflow(overflow), .o_stop_req(stop_req),
    .o_finish_req(finish_req)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: channel state 0 idle, 1 running, 2 complete
  typedef struct {
    int ch;
    int kind;
    int ts;
  } ev_t;

  int  m_mode [NUM_CH];
  int  m_lim  [NUM_CH];
  int  m_cnt  [NUM_CH];
  int  m_st   [NUM_CH];
  bit  m_pend [NUM_CH];
  int  m_pts  [NUM_CH];
  ev_t m_q[$];
  int  m_ts;
  bit  m_ovf, m_stop, m_fin;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_mode[i] = 0; m_lim[i] = 0; m_cnt[i] = 0; m_st[i] = 0;
      m_pend[i] = 1'b0; m_pts[i] = 0;
    end
    m_q.delete();
    m_ts = 0; m_ovf = 1'b0; m_stop = 1'b0; m_fin = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit  pop;
    ev_t head;
    ev_t e;
    int  gnt;
    bit  sel, hit;
    pop = (m_q.size() > 0) && evt_ready;
    head = '{ch: 0, kind: 0, ts: 0};
    if (pop) head = m_q[0];
    gnt = -1;
    if (m_q.size() < FIFO_DEPTH || pop)
      for (int i = 0; i < NUM_CH; i++)
        if (gnt < 0 && m_pend[i]) gnt = i;
    m_stop = pop && (head.kind == 1);
    if (pop && head.kind == 2) m_fin = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (gnt >= 0) begin
      e.ch = gnt; e.kind = m_mode[gnt]; e.ts = m_pts[gnt];
      m_q.push_back(e);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      sel = cfg_we && (int'(cfg_ch) == i);
      hit = !sel && enable && (m_st[i] == 1) && (m_cnt[i] == m_lim[i]);
      if (hit) begin
        if (m_pend[i] && gnt != i) m_ovf = 1'b1;
        else begin m_pend[i] = 1'b1; m_pts[i] = m_ts; end
      end else if (gnt == i) begin
        m_pend[i] = 1'b0;
      end
      if (sel) begin
        m_mode[i] = int'(cfg_mode); m_lim[i] = int'(cfg_limit);
        m_cnt[i] = 0; m_pend[i] = 1'b0;
        m_st[i] = (cfg_mode != 0) ? 1 : 0;
      end else if (m_st[i] == 1 && enable) begin
        if (m_cnt[i] != m_lim[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << CNT_W);
        else if (m_mode[i] == 3) m_cnt[i] = 0;
        else m_st[i] = 2;
      end
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic compare_all();
    logic [NUM_CH*CNT_W-1:0] ec;
    logic [NUM_CH-1:0]       ed;
    for (int i = 0; i < NUM_CH; i++) begin
      ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      ed[i] = (m_st[i] == 2);
    end
    check("count", 64'(count), 64'(ec));
    check("done", 64'(done), 64'(ed));
    check("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
    check("evt_ch", 64'(evt_ch), (m_q.size() > 0) ? 64'(m_q[0].ch) : 64'd0);
    check("evt_kind", 64'(evt_kind), (m_q.size() > 0) ? 64'(m_q[0].kind) : 64'd0);
    check("evt_time", 64'(evt_time), (m_q.size() > 0) ? 64'(m_q[0].ts) : 64'd0);
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("stop_req", 64'(stop_req), 64'(m_stop));
    check("finish_req", 64'(finish_req), 64'(m_fin));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic configure(input int ch, input int mode, input int lim);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_limit = CNT_W'(lim);
    tick();
    cfg_we = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle, released just after an edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_evt_valid", 64'(evt_valid), 64'd0);
    check("rst_finish", 64'(finish_req), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hit_ts;
    rst_n = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_limit = '0; cfg_mode = '0; evt_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // One-shot stop, limit 3
    evt_ready = 1'b1;
    enable = 1'b1;
    configure(0, 1, 3);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) hit_ts = m_ts;
      tick();
      if (k == 3) check("done0_before_hit", 64'(done[0]), 64'd0);
    end
    check("done0_on_4th_edge", 64'(done[0]), 64'd1);
    tick();
    check("stop_evt_valid", 64'(evt_valid), 64'd1);
    check("stop_evt_kind", 64'(evt_kind), 64'd1);
    check("stop_evt_time", 64'(evt_time), 64'(hit_ts));
    tick();
    check("stop_req_pulse", 64'(stop_req), 64'd1);
    tick();
    check("stop_req_clear", 64'(stop_req), 64'd0);

    // Simultaneous finish (ch1) and stop (ch2) hits
    enable = 1'b0;
    configure(1, 2, 5);
    configure(2, 1, 5);
    enable = 1'b1;
    repeat (6) tick();
    check("done12_same_edge", 64'(done[2:1]), 64'd3);
    tick();
    check("order_first_ch1", 64'(evt_ch), 64'd1);
    tick();
    check("order_second_ch2", 64'(evt_ch), 64'd2);
    repeat (4) tick();
    check("finish_sticky", 64'(finish_req), 64'd1);

    // Auto-reload limit 2 with the consumer stalled
    evt_ready = 1'b0;
    configure(0, 3, 2);
    for (int k = 1; k <= 21; k++) begin
      tick();
      check("reload_count_seq", 64'(count[CNT_W-1:0]), 64'(k % 3));
      if (k == 17) check("full_no_overflow", 64'(overflow), 64'd0);
    end
    check("overflow_after_held", 64'(overflow), 64'd1);

    // Reset with events queued; timestamp restarts from zero
    do_reset();
    enable = 1'b1;
    configure(0, 1, 0);
    tick();
    tick();
    check("ts_restart", 64'(evt_time), 64'd1);
    evt_ready = 1'b1;
    repeat (3) tick();

    // Reconfigure ch0 exactly on its hit cycle
    configure(0, 1, 2);
    repeat (2) tick();
    configure(0, 1, 2);
    check("recfg_count", 64'(count[CNT_W-1:0]), 64'd0);
    check("recfg_overflow", 64'(overflow), 64'd0);
    repeat (2) tick();
    check("recfg_no_event", 64'(evt_valid), 64'd0);

    // Every channel reloading at limit 0: higher channels lose arbitration
    enable = 1'b0;
    for (int c = 0; c < NUM_CH; c++) configure(c, 3, 0);
    enable = 1'b1;
    repeat (4) tick();
    check("arb_loss_overflow", 64'(overflow), 64'd1);

    // Random traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      enable    = ($urandom_range(0, 9) < 8);
      evt_ready = ($urandom_range(0, 9) < 5);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_ch    = 2'($urandom_range(0, NUM_CH - 1));
      cfg_limit = CNT_W'($urandom_range(0, 6));
      cfg_mode  = 2'($urandom_range(0, 3));
      tick();
      if (n == 750) do_reset();
    end
    cfg_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
